layer_wr_ctrl: RTL
==================

# layer_wr_ctrl

Upstream write controller for one LED layer's pixel RAM. It takes a framed byte stream from the host interface and packs consecutive colour bytes into per-pixel 32-bit RAM words. It drives the RAM write port (address, data, one-hot byte enable) and issues the end-of-frame pulse that starts the downstream WS281x serialiser. It also flags overflow and frame timeout.

## Interface
Parameters:
- PIXEL_NUM, 64: pixels per layer; must equal RAM depth.
- TIMEOUT_CYC, 65535: idle cycles inside a frame before abort; 16-bit counter.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- frm_sof_i  in  1  start-of-frame pulse; resets packing.
- byte_vld_i  in  1  byte_data_i valid this cycle; no backpressure.
- byte_data_i  in  8  colour byte.
- wr_en_o  out  1  RAM write strobe.
- wr_addr_o  out  6  pixel index, 0..PIXEL_NUM-1.
- wr_data_o  out  8  byte to write, replicated onto all lanes downstream.
- wr_byte_en_o  out  4  one-hot lane select, valid with wr_en_o.
- wr_done_o  out  1  one-cycle pulse: full frame written.
- ovf_o  out  1  sticky: bytes received after frame full; cleared by frm_sof_i or rst_i.
- tmo_o  out  1  one-cycle pulse: frame aborted by timeout.

## Operation
- BPP (bytes per pixel) = 3 by default; 4 with RGBW (see Configuration).
- Pixel byte k (0..BPP-1) goes to lane BPP-1-k: byte_en = 1<<(BPP-1-k). Default mode uses lanes 2,1,0; lane 3 is never written.
- Counters:
  - byte_cnt 0..BPP-1, wraps to 0, at which point pix_cnt increments.
  - pix_cnt 0..PIXEL_NUM-1.
  - tmo_cnt 16 bit, saturating.
- States:
  - IDLE: bytes ignored (no write, no flag). frm_sof_i -> FILL, counters cleared, ovf_o cleared.
  - FILL: each byte_vld_i produces one write at (pix_cnt, lane(byte_cnt)).
    - Write of byte BPP-1 of pixel PIXEL_NUM-1 -> DONE.
    - tmo_cnt clears on every byte and increments otherwise. Reaching TIMEOUT_CYC -> IDLE, tmo_o pulses, no wr_done_o.
  - DONE: one cycle, wr_done_o=1 -> FULL.
  - FULL: bytes dropped, ovf_o set. frm_sof_i -> FILL (new frame).
- frm_sof_i in any state restarts the frame from pixel 0, byte 0.
- frm_sof_i together with byte_vld_i: sof takes effect first; that byte is written as pixel 0 byte 0.
- frm_sof_i in the DONE cycle: wr_done_o still pulses; next state is FILL.

## Timing
- All outputs are registered.
- Reset values: wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_byte_en_o=0, wr_done_o=0, ovf_o=0, tmo_o=0. State=IDLE, counters 0.
- Byte accepted at cycle n -> wr_en_o/addr/data/byte_en at cycle n+1, for exactly one cycle.
- Last byte at cycle n -> final write at n+1, wr_done_o at n+2.
- Back-to-back bytes are supported at one per cycle; frame throughput is PIXEL_NUM*BPP cycles minimum.
- tmo_o: with the last byte at cycle n and no further bytes, it pulses at cycle n+TIMEOUT_CYC+1.
- rst_i mid-frame: next cycle all outputs at reset values; any partial frame is discarded and wr_done_o is not issued.

## Configuration
- LAYER_WR_RGBW_EN defined: BPP=4, byte order W,G,R,B mapped to lanes 3,2,1,0; frame = PIXEL_NUM*4 bytes.
- Undefined: BPP=3, lanes 2,1,0 only; wr_byte_en_o[3] tied 0.

## Structure
- Shared package layer_pkg: state enum (IDLE, FILL, DONE, FULL), BPP constant selected by LAYER_WR_RGBW_EN, lane_sel function (byte index -> one-hot enable).
- One sub-module: layer_wr_tmo (loadable 16-bit idle counter, clear/enable/expire), instantiated once.

## Test plan
- Default mode: sof, then 192 bytes 0x00..0xBF back-to-back -> 192 writes. Pixel 0 lanes 2,1,0 get 0x00,0x01,0x02; pixel 63 lane 0 gets 0xBF; one wr_done_o two cycles after the last byte; ovf_o=0.
- Overflow: after the full frame, send 5 more bytes -> no wr_en_o, ovf_o=1. Then sof -> ovf_o=0 and the next byte writes addr 0, lane 2.
- Timeout with TIMEOUT_CYC=16: sof plus 10 bytes, then idle -> tmo_o at last byte+17 cycles, no wr_done_o; later bytes without sof are ignored.
- Simultaneous: sof and byte 0xAA in the same cycle mid-frame -> write addr 0, byte_en 0100, data 0xAA.
- Reset mid-frame: rst_i after 50 bytes -> outputs 0 next cycle; a new frame completes normally with exactly one wr_done_o.
- LAYER_WR_RGBW_EN: 256 bytes -> lanes 3,2,1,0 per pixel; wr_done_o after byte 256.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types for the LED layer write path.
// Defining LAYER_WR_RGBW_EN selects 4-byte W,G,R,B pixels instead of 3-byte pixels.
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2,
        FULL = 2'd3
    } state_t;

`ifdef LAYER_WR_RGBW_EN
    localparam int BPP = 4;
`else
    localparam int BPP = 3;
`endif

    localparam logic [1:0] LAST_BYTE = 2'(BPP - 1);

    // Byte k of a pixel lands on lane BPP-1-k, so the first byte fills the top used lane.
    function automatic logic [3:0] lane_sel(input logic [1:0] k);
        logic [1:0] lane;
        lane = LAST_BYTE - k;
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/layer_wr_tmo.sv
// Saturating 16-bit idle counter; expire_o flags the cycle in which the count would reach TIMEOUT_CYC.
module layer_wr_tmo #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expire_o = en_i && (cnt == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/layer_wr_ctrl.sv
// Packs a framed colour byte stream into per-pixel RAM lanes and signals frame done/overflow/timeout.
// Pixel width follows LAYER_WR_RGBW_EN through layer_pkg::BPP.
module layer_wr_ctrl
    import layer_pkg::*;
#(
    parameter int PIXEL_NUM   = 64,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frm_sof_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_data_i,
    output logic       wr_en_o,
    output logic [5:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic [3:0] wr_byte_en_o,
    output logic       wr_done_o,
    output logic       ovf_o,
    output logic       tmo_o
);

    localparam logic [5:0] LAST_PIX = 6'(PIXEL_NUM - 1);

    state_t     state, state_n;
    logic [1:0] byte_cnt, byte_cnt_n, cur_byte;
    logic [5:0] pix_cnt, pix_cnt_n, cur_pix;
    logic       in_frame;
    logic       tmo_clr, tmo_en, tmo_expire;

    logic       wr_en_n, wr_done_n, ovf_n, tmo_n;
    logic [5:0] wr_addr_n;
    logic [7:0] wr_data_n;
    logic [3:0] wr_byte_en_n;

    // A start-of-frame overrides whatever state we are in, so the same-cycle byte is pixel 0 byte 0.
    assign in_frame = frm_sof_i || (state == FILL);
    assign cur_byte = frm_sof_i ? 2'd0 : byte_cnt;
    assign cur_pix  = frm_sof_i ? 6'd0 : pix_cnt;
    assign tmo_clr  = frm_sof_i || byte_vld_i;
    assign tmo_en   = (state == FILL) && !tmo_clr;

    layer_wr_tmo #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_n      = state;
        byte_cnt_n   = cur_byte;
        pix_cnt_n    = cur_pix;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr_o;
        wr_data_n    = wr_data_o;
        wr_byte_en_n = 4'b0000;
        wr_done_n    = (state == DONE);
        ovf_n        = frm_sof_i ? 1'b0 : ovf_o;
        tmo_n        = 1'b0;

        if (frm_sof_i) begin
            state_n = FILL;
        end else if (state == DONE) begin
            state_n = FULL;
        end

        if (in_frame) begin
            if (byte_vld_i) begin
                wr_en_n      = 1'b1;
                wr_addr_n    = cur_pix;
                wr_data_n    = byte_data_i;
                wr_byte_en_n = lane_sel(cur_byte);
                if (cur_byte == LAST_BYTE) begin
                    byte_cnt_n = 2'd0;
                    if (cur_pix == LAST_PIX) begin
                        state_n = DONE;
                    end else begin
                        pix_cnt_n = cur_pix + 6'd1;
                    end
                end else begin
                    byte_cnt_n = cur_byte + 2'd1;
                end
            end else if (tmo_expire) begin
                state_n = IDLE;
                tmo_n   = 1'b1;
            end
        end else if (byte_vld_i && ((state == DONE) || (state == FULL))) begin
            ovf_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            pix_cnt      <= 6'd0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= 6'd0;
            wr_data_o    <= 8'd0;
            wr_byte_en_o <= 4'b0000;
            wr_done_o    <= 1'b0;
            ovf_o        <= 1'b0;
            tmo_o        <= 1'b0;
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            pix_cnt      <= pix_cnt_n;
            wr_en_o      <= wr_en_n;
            wr_addr_o    <= wr_addr_n;
            wr_data_o    <= wr_data_n;
            wr_byte_en_o <= wr_byte_en_n;
            wr_done_o    <= wr_done_n;
            ovf_o        <= ovf_n;
            tmo_o        <= tmo_n;
        end
    end

endmodule
